// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants and types for the instruction-fetch stage
// Purpose: default widths, reset PC, NOP encoding, FSM states and next-PC select codes.
// Ports:   none (package).
package if_stage_pkg;

  localparam int unsigned IF_ADD_SIZE = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NPC_KEEP    = 2'd0,
    NPC_INC     = 2'd1,
    NPC_TARGET  = 2'd2,
    NPC_PENDING = 2'd3
  } npc_sel_e;

endpackage

// File: rtl/if_stage_pc_unit.sv
// rtl/if_stage_pc_unit.sv - PC register, pending redirect target and next-PC selection
// Purpose: holds the fetch PC and a parked redirect target used while an old fetch drains.
// Ports:   i_clk, i_rstn       clock, sync active-low reset
//          i_npc_sel           next-PC source (keep / +4 / target / pending)
//          i_pend_load         capture i_target into the pending register
//          i_target            redirect target (low two bits are masked off)
//          o_pc, o_pc_plus4    current PC and PC+4 (modulo 2^W)
module if_stage_pc_unit
  import if_stage_pkg::*;
#(
  parameter int unsigned       W        = 32,
  parameter logic [W-1:0]      RESET_PC = '0
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  npc_sel_e     i_npc_sel,
  input  logic         i_pend_load,
  input  logic [W-1:0] i_target,
  output logic [W-1:0] o_pc,
  output logic [W-1:0] o_pc_plus4
);

  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] pend_q, pend_d;
  logic [W-1:0] target_aligned;

  // Instructions are word aligned; a misaligned target is silently rounded down.
  assign target_aligned = i_target & ~W'(3);
  assign o_pc           = pc_q;
  assign o_pc_plus4     = pc_q + W'(4);

  always_comb begin
    pc_d = pc_q;
    unique case (i_npc_sel)
      NPC_INC:     pc_d = o_pc_plus4;
      NPC_TARGET:  pc_d = target_aligned;
      NPC_PENDING: pc_d = pend_q;
      default:     pc_d = pc_q;
    endcase
  end

  assign pend_d = i_pend_load ? target_aligned : pend_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pc_q   <= RESET_PC;
      pend_q <= '0;
    end else begin
      pc_q   <= pc_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - RV32I instruction-fetch stage with req/ack memory port and IF/ID register
// Purpose: fetch FSM, hold buffer for data arriving under stall, and the IF/ID pipeline register.
// Ports:   i_clk, i_rstn                     clock, sync active-low reset
//          i_stall, i_flush                  hazard-unit hold / bubble-insert
//          i_pc_sel, i_pc_target             redirect from execute
//          o_imem_req, o_imem_addr           fetch request and address (= PC)
//          i_imem_ack, i_imem_rdata          single-cycle completion with data
//          o_id_instr, o_id_pc, o_id_pc_plus4, o_id_valid   IF/ID register
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned            I_ADD_SIZE = IF_ADD_SIZE,
  parameter logic [I_ADD_SIZE-1:0]  RESET_PC   = I_ADD_SIZE'(IF_RESET_PC)
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_pc_sel,
  input  logic [I_ADD_SIZE-1:0] i_pc_target,
  output logic                  o_imem_req,
  output logic [I_ADD_SIZE-1:0] o_imem_addr,
  input  logic                  i_imem_ack,
  input  logic [I_ADD_SIZE-1:0] i_imem_rdata,
  output logic [I_ADD_SIZE-1:0] o_id_instr,
  output logic [I_ADD_SIZE-1:0] o_id_pc,
  output logic [I_ADD_SIZE-1:0] o_id_pc_plus4,
  output logic                  o_id_valid
);

  localparam logic [I_ADD_SIZE-1:0] NOP = I_ADD_SIZE'(NOP_INSTR);

  state_e                  state_q, state_d;
  npc_sel_e                npc_sel;
  logic                    pend_load;
  logic [I_ADD_SIZE-1:0]   pc, pc_plus4;
  logic [I_ADD_SIZE-1:0]   hold_q, hold_d;
  logic                    ld;
  logic [I_ADD_SIZE-1:0]   ld_instr;
  logic [I_ADD_SIZE-1:0]   id_instr_q, id_instr_d;
  logic [I_ADD_SIZE-1:0]   id_pc_q, id_pc_d;
  logic [I_ADD_SIZE-1:0]   id_pc4_q, id_pc4_d;
  logic                    id_valid_q, id_valid_d;

  if_stage_pc_unit #(
    .W        (I_ADD_SIZE),
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_npc_sel   (npc_sel),
    .i_pend_load (pend_load),
    .i_target    (i_pc_target),
    .o_pc        (pc),
    .o_pc_plus4  (pc_plus4)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rstn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state. Ack is only looked at in FETCH/DRAIN, so a stray ack
  // (IDLE, HOLD, or after a reset abandoned a request) is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (i_pc_sel)                 state_d = i_imem_ack ? FETCH : DRAIN;
        else if (i_imem_ack && i_stall) state_d = HOLD;
      end
      HOLD:  if (i_pc_sel || !i_stall) state_d = FETCH;
      DRAIN: if (i_imem_ack)          state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_imem_req = (state_q == FETCH) || (state_q == DRAIN);
  end
  assign o_imem_addr = pc;

  // PC source, pending-target capture, hold buffer and IF/ID load candidate.
  always_comb begin
    npc_sel   = NPC_KEEP;
    pend_load = 1'b0;
    hold_d    = hold_q;
    ld        = 1'b0;
    ld_instr  = i_imem_rdata;
    unique case (state_q)
      FETCH: begin
        if (i_pc_sel) begin
          // Address must stay put until ack, so an unacked redirect is parked.
          if (i_imem_ack) npc_sel   = NPC_TARGET;
          else            pend_load = 1'b1;
        end else if (i_imem_ack) begin
          if (i_stall) begin
            hold_d = i_imem_rdata;
          end else begin
            ld      = 1'b1;
            npc_sel = NPC_INC;
          end
        end
      end
      HOLD: begin
        if (i_pc_sel) begin
          npc_sel = NPC_TARGET;
        end else if (!i_stall) begin
          ld       = 1'b1;
          ld_instr = hold_q;
          npc_sel  = NPC_INC;
        end
      end
      DRAIN: begin
        // A redirect arriving with the ack is newer than the parked one.
        if (i_imem_ack) npc_sel   = i_pc_sel ? NPC_TARGET : NPC_PENDING;
        else if (i_pc_sel) pend_load = 1'b1;
      end
      default: ;
    endcase
  end

  // IF/ID: flush beats stall beats load/bubble.
  always_comb begin
    id_instr_d = NOP;
    id_pc_d    = '0;
    id_pc4_d   = '0;
    id_valid_d = 1'b0;
    if (i_flush) begin
      id_valid_d = 1'b0;
    end else if (i_stall) begin
      id_instr_d = id_instr_q;
      id_pc_d    = id_pc_q;
      id_pc4_d   = id_pc4_q;
      id_valid_d = id_valid_q;
    end else if (ld) begin
      id_instr_d = ld_instr;
      id_pc_d    = pc;
      id_pc4_d   = pc_plus4;
      id_valid_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      hold_q     <= '0;
      id_instr_q <= NOP;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign o_id_instr    = id_instr_q;
  assign o_id_pc       = id_pc_q;
  assign o_id_pc_plus4 = id_pc4_q;
  assign o_id_valid    = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, sel, ack;
  logic [31:0] tgt, rdata;
  logic        req, id_valid;
  logic [31:0] addr, id_instr, id_pc, id_pc4;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: fetcher described by three flags and the architectural values.
  bit          m_idle, m_hold, m_drain;
  logic [31:0] m_pc, m_pend, m_buf;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  always #5 clk = ~clk;

  if_stage dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_pc_sel      (sel),
    .i_pc_target   (tgt),
    .o_imem_req    (req),
    .o_imem_addr   (addr),
    .i_imem_ack    (ack),
    .i_imem_rdata  (rdata),
    .o_id_instr    (id_instr),
    .o_id_pc       (id_pc),
    .o_id_pc_plus4 (id_pc4),
    .o_id_valid    (id_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        ld;
    logic [31:0] li, lp, al;
    ld = 1'b0; li = NOP; lp = 32'h0;
    al = tgt & 32'hFFFF_FFFC;
    if (!rstn) begin
      m_idle = 1; m_hold = 0; m_drain = 0;
      m_pc = 32'h0; m_pend = 32'h0; m_buf = 32'h0;
      e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
      return;
    end
    if (m_idle) begin
      m_idle = 0;
    end else if (m_hold) begin
      if (sel) begin
        m_pc = al; m_hold = 0;
      end else if (!stall) begin
        ld = 1; li = m_buf; lp = m_pc; m_pc = m_pc + 4; m_hold = 0;
      end
    end else if (m_drain) begin
      if (ack) begin
        m_pc = sel ? al : m_pend; m_drain = 0;
      end else if (sel) begin
        m_pend = al;
      end
    end else begin
      if (sel) begin
        if (ack) m_pc = al;
        else begin m_pend = al; m_drain = 1; end
      end else if (ack) begin
        if (stall) begin m_buf = rdata; m_hold = 1; end
        else begin ld = 1; li = rdata; lp = m_pc; m_pc = m_pc + 4; end
      end
    end
    if (flush || (!stall && !ld)) begin
      e_instr = NOP; e_pc = 0; e_pc4 = 0; e_valid = 0;
    end else if (!stall) begin
      e_instr = li; e_pc = lp; e_pc4 = lp + 4; e_valid = 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("req",         32'(req),      32'(!m_idle && !m_hold));
    check_eq("addr",        addr,          m_pc);
    check_eq("id_instr",    id_instr,      e_instr);
    check_eq("id_pc",       id_pc,         e_pc);
    check_eq("id_pc_plus4", id_pc4,        e_pc4);
    check_eq("id_valid",    32'(id_valid), 32'(e_valid));
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic p,
                       input logic [31:0] t, input logic a);
    rstn = r; stall = s; flush = f; sel = p; tgt = t; ack = a;
    rdata = m_pc ^ KEY;
    tick();
  endtask

  initial begin
    rstn = 0; stall = 0; flush = 0; sel = 0; tgt = 0; ack = 0; rdata = 0;
    m_pc = 0;

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    check_eq("rst_instr", id_instr, NOP);
    check_eq("rst_req",   32'(req), 32'd0);

    // Zero-wait streaming from reset
    drive(1, 0, 0, 0, 0, 1);
    check_eq("start_req", 32'(req), 32'd1);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("s_pc0", id_pc, 32'h0);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("s_pc4", id_pc, 32'h4);
    check_eq("s_addr8", addr, 32'h8);

    // Ack delayed three cycles at pc=8
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0);
      check_eq("wait_addr",  addr, 32'h8);
      check_eq("wait_valid", 32'(id_valid), 32'd0);
    end
    drive(1, 0, 0, 0, 0, 1);
    check_eq("late_instr", id_instr, 32'hA5A5_0008);
    check_eq("late_pc4",   id_pc4,   32'hC);

    // Redirect to 0x103 while pc=12 is outstanding
    drive(1, 0, 0, 1, 32'h103, 0);
    drive(1, 0, 0, 0, 0, 0);
    check_eq("drain_addr", addr, 32'hC);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("redir_addr",  addr, 32'h100);
    check_eq("redir_valid", 32'(id_valid), 32'd0);

    // Ack under stall goes to HOLD
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 0, 1);
    check_eq("hold_req", 32'(req), 32'd0);
    check_eq("hold_pc",  id_pc, 32'h100);
    drive(1, 1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    check_eq("rel_pc",   id_pc, 32'h104);
    check_eq("rel_addr", addr,  32'h108);

    // Flush with stall on a valid IF/ID
    drive(1, 1, 1, 0, 0, 1);
    check_eq("flush_instr", id_instr, NOP);
    check_eq("flush_addr",  addr, 32'h108);
    drive(1, 0, 0, 0, 0, 0);

    // PC wrap at the top of the address space
    drive(1, 0, 0, 1, 32'hFFFF_FFFE, 1);
    check_eq("wrap_tgt", addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("wrap_pc4",  id_pc4, 32'h0);
    check_eq("wrap_addr", addr,   32'h0);

    // Reset abandons an outstanding request; late ack ignored
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    check_eq("post_rst_valid", 32'(id_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rstn  = ($urandom_range(0, 99) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      sel   = ($urandom_range(0, 7) == 0);
      tgt   = $urandom;
      ack   = $urandom_range(0, 1) == 1;
      rdata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
